amba_apb_master: RTL and testbench
==================================

Name: amba_apb_master

Overview:
APB initiator (requester) for the team's 8-bit-address / 8-bit-data APB bus. Accepts single read/write commands on a valid/ready command port and runs the APB SETUP→ACCESS sequence with wait-state support. Returns read data and status on a valid/ready response port. Sits between a local controller (CPU bridge, test sequencer) and one APB completer selected by psel.

Parameters:
TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; 0 = wait forever; legal 0..255
RDATA_LAG, 1, 0 = sample prdata on the completion edge (standard APB); 1 = sample prdata one cycle after completion, for completers that register read data on the completion edge

Ports:
pclk  in  1  bus clock, all logic on rising edge
preset  in  1  asynchronous, active-low reset (0 = in reset)
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  8  target address
cmd_wdata  in  8  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  8  read data (0 for writes and on error)
rsp_err  out  1  1 = transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  8  APB address
pwdata  out  8  APB write data
pready  in  1  APB completer ready
prdata  in  8  APB read data

Behaviour:
- Reset (preset=0, async): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter = 0; cmd_ready = 0 while in reset. Reset mid-transfer drops psel/penable immediately; no response is produced for the aborted command.
- cmd_ready = (state==IDLE) & preset; combinational. All APB and rsp outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, LAG, RESP.
- IDLE: on cmd handshake, register write/addr/wdata into pwrite/paddr/pwdata; next state SETUP. Otherwise psel=0, penable=0.
- SETUP (exactly 1 cycle): psel=1, penable=0; pready ignored; next state ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable. The counter increments each ACCESS cycle without pready.
  - pready=1: transfer completes at this edge. psel and penable go to 0.
    - Write, or read with RDATA_LAG=0 → RESP; read data captured from prdata at this edge.
    - Read with RDATA_LAG=1 → LAG.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with pready=0: abort at this edge. psel and penable go to 0; rsp_err=1; rsp_rdata=0; → RESP.
  - pready=1 in the cycle the timeout would fire: completion wins, rsp_err=0.
- LAG (1 cycle, psel=0, penable=0): rsp_rdata <= prdata at end of cycle; → RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_err held until rsp_ready=1. Then rsp_valid <= 0, counter cleared, → IDLE. rsp_rdata is held until the next response.
- Writes always return rsp_rdata=0, rsp_err=0 (unless timed out).
- Minimum command-accept to rsp_valid latency:
  - write, or read with RDATA_LAG=0: 3 cycles (SETUP, ACCESS, RESP)
  - read with RDATA_LAG=1: 4 cycles
- Throughput: one outstanding command. The next command can be accepted the cycle after the RESP handshake.
- pready outside ACCESS is ignored. prdata is only sampled as above.
- paddr/pwdata keep their last values in IDLE; no X-propagation is required.

Test Plan:
- Write, zero wait: cmd write addr 0x05 data 0xA5, pready tied 1 in ACCESS → SETUP cycle psel=1/penable=0, next cycle penable=1, paddr=0x05, pwdata=0xA5, pwrite=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0x00.
- Read, RDATA_LAG=1, model completer registering 0x3C on completion edge for addr 0x05 → rsp_rdata=0x3C, rsp_valid 4 cycles after accept; with RDATA_LAG=0 and combinational prdata=0x3C → rsp_rdata=0x3C at 3 cycles.
- Wait states: pready low for 3 ACCESS cycles, then high → ACCESS lasts 4 cycles with stable paddr/pwdata/pwrite; rsp_err=0.
- Timeout: TIMEOUT=4, pready held 0 → exactly 4 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0. Repeat with pready=1 on the 4th ACCESS cycle → rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready=0, and cmd_valid held high is not accepted until the cycle after rsp_ready=1.
- Reset mid-ACCESS: assert preset=0 asynchronously → psel/penable/rsp_valid 0 before the next clock edge; after release, state IDLE, cmd_ready=1, no stale response.

Source files
------------

// File: rtl/amba_apb_master.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS with wait states and timeout,
// and returns read data and status on a valid/ready response port.
module amba_apb_master #(
  parameter int TIMEOUT   = 16,
  parameter int RDATA_LAG = 1
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic       pready,
  input  logic [7:0] prdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_LAG    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic       LP_TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] LP_TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
  localparam logic       LP_LAG     = (RDATA_LAG != 0);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic [7:0] r_paddr;
  logic [7:0] r_pwdata;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_psel_nxt;
  logic       w_penable_nxt;
  logic       w_pwrite_nxt;
  logic [7:0] w_paddr_nxt;
  logic [7:0] w_pwdata_nxt;
  logic       w_rsp_valid_nxt;
  logic [7:0] w_rsp_rdata_nxt;
  logic       w_rsp_err_nxt;
  logic       w_cmd_hs;

  assign cmd_ready = (r_state == S_IDLE) & preset;
  assign w_cmd_hs  = cmd_valid & cmd_ready;

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // State and registered-output update; reset drops the bus immediately.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 8'd0;
      r_pwdata    <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        w_penable_nxt = 1'b0;
        if (w_cmd_hs) begin
          w_pwrite_nxt = cmd_write;
          w_paddr_nxt  = cmd_addr;
          w_pwdata_nxt = cmd_wdata;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
        end else begin
          w_psel_nxt   = 1'b0;
        end
      end

      S_SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready) begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          if (!r_pwrite && LP_LAG) begin
            w_state_nxt = S_LAG;
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b0;
            w_rsp_rdata_nxt = r_pwrite ? 8'd0 : prdata;
          end
        end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
          // Completer never answered: abort with an error response.
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_LAG: begin
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_rdata_nxt = prdata;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cnt_nxt       = 8'd0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_cnt_nxt       = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_amba_apb_master.sv
// Bench for amba_apb_master: two instances (registered-read-data and combinational-read-data
// completers) driven with directed and random commands against a transaction-level model.
module tb_amba_apb_master;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       preset    [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_write [2];
  logic [7:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       psel      [2];
  logic       penable   [2];
  logic       pwrite    [2];
  logic [7:0] paddr     [2];
  logic [7:0] pwdata    [2];
  logic       pready    [2];
  logic [7:0] prdata    [2];
  int         wait_cfg  [2];
  logic [7:0] ref_mem   [2][16];
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];
    int         acc_cnt  = 0;
    logic [7:0] prdata_r = 8'h00;
    logic [7:0] junk     = 8'h00;

    amba_apb_master #(.TIMEOUT(TO), .RDATA_LAG((g == 0) ? 1 : 0)) u_dut (
      .pclk(clk), .preset(preset[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g]),
      .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]), .paddr(paddr[g]),
      .pwdata(pwdata[g]), .pready(pready[g]), .prdata(prdata[g])
    );

    // Completer: answers after wait_cfg stalled ACCESS cycles; instance 0 registers read data.
    assign pready[g] = psel[g] && penable[g] && (acc_cnt == wait_cfg[g]);
    assign prdata[g] = (g == 0) ? prdata_r : ((psel[g] && penable[g]) ? mem[paddr[g]] : junk);

    always @(posedge clk) begin
      junk <= 8'($urandom);
      if (psel[g] && penable[g] && pready[g]) begin
        acc_cnt  <= 0;
        prdata_r <= mem[paddr[g]];
        if (pwrite[g]) mem[paddr[g]] <= pwdata[g];
      end else begin
        acc_cnt  <= (psel[g] && penable[g]) ? acc_cnt + 1 : 0;
        prdata_r <= 8'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command end to end; starts and ends on a falling edge with the DUT idle.
  task automatic do_txn(input int d, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input int wt, input int bp, input bit hold);
    int         a_exp, lat_exp, lat, acc, n;
    logic       e_exp;
    logic [7:0] r_exp;
    if (wt + 1 <= TO) begin
      a_exp = wt + 1;
      e_exp = 1'b0;
    end else begin
      a_exp = TO;
      e_exp = 1'b1;
    end
    r_exp = (!wr && !e_exp) ? ref_mem[d][addr[3:0]] : 8'h00;
    if (wr && !e_exp) ref_mem[d][addr[3:0]] = wdata;
    lat_exp = 2 + a_exp + ((d == 0 && !wr && !e_exp) ? 1 : 0);

    wait_cfg[d]  = wt;
    cmd_valid[d] = 1'b1;
    cmd_write[d] = wr;
    cmd_addr[d]  = addr;
    cmd_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    n = 0;
    while (!cmd_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", cmd_ready[d], 1'b1);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    chk("setup_phase", {psel[d], penable[d]}, 2'b10);

    lat = 1;
    acc = 0;
    while (!rsp_valid[d] && lat < 40) begin
      if (psel[d] && penable[d]) begin
        acc++;
        chk("access_bus", {pwrite[d], paddr[d], pwdata[d]}, {wr, addr, wdata});
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, lat_exp);
    chk("access_cycles", acc, a_exp);
    chk("rsp_err", rsp_err[d], e_exp);
    chk("rsp_rdata", rsp_rdata[d], r_exp);
    chk("resp_bus_idle", {psel[d], penable[d]}, 2'b00);

    for (int i = 0; i < bp; i++) begin
      if (hold) cmd_valid[d] = 1'b1;
      @(negedge clk);
      chk("backpressure", {rsp_valid[d], cmd_ready[d], rsp_err[d], rsp_rdata[d]},
          {1'b1, 1'b0, e_exp, r_exp});
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    cmd_valid[d] = 1'b0;
    chk("post_rsp", {rsp_valid[d], cmd_ready[d], rsp_rdata[d]}, {1'b0, 1'b1, r_exp});
  endtask

  // Asynchronous reset in the middle of a stalled ACCESS phase.
  task automatic reset_mid(input int d);
    wait_cfg[d]  = 1000;
    cmd_valid[d] = 1'b1;
    cmd_write[d] = 1'b1;
    cmd_addr[d]  = 8'h07;
    cmd_wdata[d] = 8'hEE;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    @(negedge clk);
    chk("rst_pre_access", {psel[d], penable[d]}, 2'b11);
    #2 preset[d] = 1'b0;
    #1 chk("rst_async", {psel[d], penable[d], rsp_valid[d], cmd_ready[d]}, 4'b0000);
    @(negedge clk);
    preset[d] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_after", {cmd_ready[d], rsp_valid[d], psel[d]}, 3'b100);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      preset[d]    = 1'b0;
      cmd_valid[d] = 1'b0;
      cmd_write[d] = 1'b0;
      cmd_addr[d]  = 8'h00;
      cmd_wdata[d] = 8'h00;
      rsp_ready[d] = 1'b0;
      wait_cfg[d]  = 0;
      for (int a = 0; a < 16; a++) ref_mem[d][a] = 8'h00;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", {psel[d], penable[d], pwrite[d], paddr[d], pwdata[d],
                            rsp_valid[d], rsp_err[d], rsp_rdata[d], cmd_ready[d]}, 32'h0);
    end
    @(negedge clk);
    preset[0] = 1'b1;
    preset[1] = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk("idle_ready", cmd_ready[d], 1'b1);
      do_txn(d, 1'b1, 8'h05, 8'hA5, 0, 0, 1'b0);
      for (int a = 0; a < 16; a++) begin
        if (a != 5) do_txn(d, 1'b1, 8'(a), 8'($urandom), 0, 0, 1'b0);
      end
      do_txn(d, 1'b0, 8'h05, 8'h00, 0, 0, 1'b0);
      do_txn(d, 1'b1, 8'h05, 8'h3C, 0, 0, 1'b0);
      do_txn(d, 1'b0, 8'h05, 8'h11, 0, 0, 1'b0);
      do_txn(d, 1'b1, 8'h0A, 8'h77, 3, 0, 1'b0);
      do_txn(d, 1'b0, 8'h0A, 8'h00, 3, 0, 1'b0);
      do_txn(d, 1'b0, 8'h03, 8'h00, 10, 0, 1'b0);
      do_txn(d, 1'b1, 8'h03, 8'h99, 10, 0, 1'b0);
      do_txn(d, 1'b0, 8'h03, 8'h00, 3, 0, 1'b0);
      do_txn(d, 1'b0, 8'h05, 8'h00, 0, 5, 1'b1);
      do_txn(d, 1'b1, 8'h0C, 8'h5A, 0, 0, 1'b0);
      reset_mid(d);
      do_txn(d, 1'b0, 8'h07, 8'h00, 1, 0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        do_txn(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
